// File: rtl/damage_accumulator.sv
// Purpose : sums the attack values of alive, engaged friendly slots over one combat tick,
//           saturating at 511, and presents the total with the latched target code.
// Latency : Start sampled at edge 0, one slot per clock, result and Done at edge 16.
//           Start is ignored while Busy, and there is no output backpressure.
// Ports   : Clk/Reset_n are the clock and async active-low reset. Start, unitAlive,
//           unitInRange and targetIndex form the scan request and are latched at Start.
//           attackAddr/attackData form the async-read attack table port.
//           totalDamage and damageSelect are the held result. Busy is high while scanning.
//           Done pulses for one cycle when a new result is valid.
module damage_accumulator #(
  parameter int NUM_SLOTS = 16,
  parameter int ATK_W     = 8,
  parameter int SUM_W     = 9,
  parameter int TOWER_SEL = 16,
  parameter int NO_TARGET = 31
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Start,
  input  logic [NUM_SLOTS-1:0]         unitAlive,
  input  logic [NUM_SLOTS-1:0]         unitInRange,
  input  logic [4:0]                   targetIndex,
  output logic [$clog2(NUM_SLOTS)-1:0] attackAddr,
  input  logic [ATK_W-1:0]             attackData,
  output logic [SUM_W-1:0]             totalDamage,
  output logic [4:0]                   damageSelect,
  output logic                         Busy,
  output logic                         Done
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int SEL_W  = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SEL_W-1:0]  TOWER_CODE = SEL_W'(TOWER_SEL);
  localparam logic [SEL_W-1:0]  NONE_CODE  = SEL_W'(NO_TARGET);
  localparam logic [SUM_W-1:0]  SUM_MAX    = {SUM_W{1'b1}};

  logic [0:0]           state_q, state_d;
  logic [NUM_SLOTS-1:0] mask_q,  mask_d;
  logic [SEL_W-1:0]     tgt_q,   tgt_d;
  logic [SLOT_W-1:0]    cnt_q,   cnt_d;
  logic [SUM_W-1:0]     sum_q,   sum_d;
  logic [SUM_W-1:0]     total_q, total_d;
  logic [SEL_W-1:0]     sel_q,   sel_d;
  logic                 done_q,  done_d;

  // One spare bit catches overflow. Max sum plus max attack still fits in SUM_W+1 bits.
  logic [SUM_W:0]       add_wide;
  logic [SUM_W-1:0]     sum_sat;
  logic [SUM_W-1:0]     sum_nxt;

  always_comb begin
    add_wide = {1'b0, sum_q} + {{(SUM_W + 1 - ATK_W){1'b0}}, attackData};
    sum_sat  = add_wide[SUM_W] ? SUM_MAX : add_wide[SUM_W-1:0];
    sum_nxt  = mask_q[cnt_q] ? sum_sat : sum_q;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    total_d = total_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_SCAN;
          mask_d  = unitAlive & unitInRange;
          tgt_d   = targetIndex;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        sum_d = sum_nxt;
        // The counter wraps back to 0 after the last slot, so attackAddr idles at 0.
        cnt_d = cnt_q + SLOT_W'(1);
        if (cnt_q == LAST_SLOT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // The final sum includes this cycle's slot, so the output uses sum_nxt, not sum_q.
          if (tgt_q > TOWER_CODE) begin
            total_d = '0;
            sel_d   = NONE_CODE;
          end else begin
            total_d = sum_nxt;
            sel_d   = tgt_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      total_q <= '0;
      sel_q   <= NONE_CODE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      total_q <= total_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign attackAddr   = cnt_q;
  assign totalDamage  = total_q;
  assign damageSelect = sel_q;
  assign Busy         = (state_q == ST_SCAN);
  assign Done         = done_q;

endmodule

// File: tb/tb_damage_accumulator.sv
module tb_damage_accumulator;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [15:0] unitAlive;
  logic [15:0] unitInRange;
  logic [4:0]  targetIndex;
  logic [3:0]  attackAddr;
  logic [7:0]  attackData;
  logic [8:0]  totalDamage;
  logic [4:0]  damageSelect;
  logic        Busy;
  logic        Done;

  logic [7:0]  atk [16];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign attackData = atk[attackAddr];

  damage_accumulator dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .unitAlive(unitAlive), .unitInRange(unitInRange), .targetIndex(targetIndex),
    .attackAddr(attackAddr), .attackData(attackData),
    .totalDamage(totalDamage), .damageSelect(damageSelect),
    .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // kind 0: attack[i]=i+1, kind 1: every attack 255, kind 2: 10 at slot 0, 20 at slot 2, others 100
  task automatic load_atk(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       atk[i] = 8'(i + 1);
        1:       atk[i] = 8'd255;
        default: atk[i] = (i == 0) ? 8'd10 : (i == 2) ? 8'd20 : 8'd100;
      endcase
    end
  endtask

  // Reference: an unmasked target 0..16 gets the clamped plain sum of the selected attacks.
  function automatic int model_total(input logic [15:0] al, input logic [15:0] ir,
                                     input logic [4:0] tg);
    int s;
    s = 0;
    if (tg > 5'd16) return 0;
    for (int i = 0; i < 16; i++)
      if (al[i] && ir[i]) s += int'(atk[i]);
    return (s > 511) ? 511 : s;
  endfunction

  function automatic int model_sel(input logic [4:0] tg);
    return (tg > 5'd16) ? 31 : int'(tg);
  endfunction

  task automatic check_reset_vals(input string nm);
    chk({nm, " totalDamage"}, int'(totalDamage), 0);
    chk({nm, " damageSelect"}, int'(damageSelect), 31);
    chk({nm, " Busy"}, int'(Busy), 0);
    chk({nm, " Done"}, int'(Done), 0);
    chk({nm, " attackAddr"}, int'(attackAddr), 0);
  endtask

  // mode 0: plain scan, 1: scramble requests every scan cycle, 2: extra Start at scan cycle 5
  task automatic run_scan(input logic [15:0] al, input logic [15:0] ir, input logic [4:0] tg,
                          input int mode, input int exp_tot, input int exp_sel, input string nm);
    int old_tot, old_sel, done_at, addr_bad, busy_n, held_bad;
    old_tot = int'(totalDamage);
    old_sel = int'(damageSelect);
    done_at = -1; addr_bad = 0; busy_n = 0; held_bad = 0;
    @(negedge Clk);
    unitAlive = al; unitInRange = ir; targetIndex = tg; Start = 1'b1;
    for (int j = 0; j < 40 && done_at < 0; j++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        done_at = j;
        chk({nm, " Busy at Done"}, int'(Busy), 0);
      end else begin
        if (Busy) busy_n++;
        if (int'(attackAddr) != j) addr_bad++;
        if (int'(totalDamage) != old_tot || int'(damageSelect) != old_sel) held_bad++;
      end
      if (mode == 1) begin
        unitAlive = ~unitAlive; unitInRange = ~unitInRange; targetIndex = targetIndex + 5'd1;
      end
      if (mode == 2 && j == 4) begin
        Start = 1'b1; unitAlive = 16'h0000; targetIndex = 5'd2;
      end
    end
    chk({nm, " done cycle"}, done_at, 16);
    chk({nm, " addr steps"}, addr_bad, 0);
    chk({nm, " busy cycles"}, busy_n, 16);
    chk({nm, " held during scan"}, held_bad, 0);
    chk({nm, " totalDamage"}, int'(totalDamage), exp_tot);
    chk({nm, " damageSelect"}, int'(damageSelect), exp_sel);
    @(negedge Clk);
    chk({nm, " Done one cycle"}, int'(Done), 0);
  endtask

  typedef struct {
    logic [15:0] al;
    logic [15:0] ir;
    logic [4:0]  tg;
    int          kind;
    int          mode;
    int          exp_tot;
    int          exp_sel;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int done_at;
    int dones;
    logic [15:0] ral, rir;
    logic [4:0]  rtg;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 5'd3,  0, 0, 136, 3};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 5'd16, 1, 0, 511, 16};
    vecs[2] = '{16'hFFFF, 16'h0005, 5'd7,  2, 1, 30,  7};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 5'd20, 0, 2, 0,   31};
    vecs[4] = '{16'h0000, 16'hFFFF, 5'd16, 1, 0, 0,   16};
    vecs[5] = '{16'h00FF, 16'hFF00, 5'd0,  1, 0, 0,   0};
    vecs[6] = '{16'h8001, 16'hFFFF, 5'd15, 0, 0, 17,  15};
    vecs[7] = '{16'h0F0F, 16'hFFFF, 5'd31, 1, 0, 0,   31};
    vecs[8] = '{16'h0003, 16'h0003, 5'd16, 1, 0, 510, 16};
    vecs[9] = '{16'h0007, 16'hFFFF, 5'd1,  1, 0, 511, 1};

    Reset_n = 1'b0; Start = 1'b0;
    unitAlive = '0; unitInRange = '0; targetIndex = '0;
    load_atk(0);
    repeat (3) @(negedge Clk);
    check_reset_vals("reset held");
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check_reset_vals("after reset");

    for (int v = 0; v < 10; v++) begin
      load_atk(vecs[v].kind);
      run_scan(vecs[v].al, vecs[v].ir, vecs[v].tg, vecs[v].mode,
               vecs[v].exp_tot, vecs[v].exp_sel, $sformatf("vec%0d", v));
    end

    // A reset pulse at scan cycle 8 must clear everything and suppress Done.
    load_atk(0);
    @(negedge Clk);
    unitAlive = 16'hFFFF; unitInRange = 16'hFFFF; targetIndex = 5'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (8) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_reset_vals("mid-scan reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    chk("no Done after reset", dones, 0);
    run_scan(16'hFFFF, 16'hFFFF, 5'd3, 0, 136, 3, "scan after reset");

    // A Start in the Done cycle begins a new scan, and the old result is held until its end.
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    done_at = -1;
    for (int j = 0; j < 40 && done_at < 0; j++) begin
      @(negedge Clk);
      if (Done) done_at = j;
    end
    chk("b2b first done", done_at, 15);
    unitAlive = 16'h0001; unitInRange = 16'hFFFF; targetIndex = 5'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b restart busy", int'(Busy), 1);
    chk("b2b old total held", int'(totalDamage), 136);
    chk("b2b old select held", int'(damageSelect), 3);
    done_at = -1;
    for (int j = 1; j < 40 && done_at < 0; j++) begin
      @(negedge Clk);
      if (Done) done_at = j;
    end
    chk("b2b second done cycle", done_at, 16);
    chk("b2b second total", int'(totalDamage), 1);
    chk("b2b second select", int'(damageSelect), 9);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 16; i++)
        atk[i] = 8'($urandom_range(0, (k % 2) ? 255 : 40));
      ral = 16'($urandom);
      rir = 16'($urandom);
      rtg = (k % 3 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 16));
      run_scan(ral, rir, rtg, 0, model_total(ral, rir, rtg), model_sel(rtg),
               $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/damage_accumulator.md
Name: damage_accumulator

Overview:
Upstream stage of the damage decoder. On each combat tick, scans the 16 friendly unit slots one per clock, sums the attack values of alive units engaged in combat, and presents the saturated 9-bit total plus the 5-bit target select. The decoder consumes exactly these two values; one instance serves the friendly side and one serves the enemy side. Attack values are read through an async-read attack table port.

Parameters:
NUM_SLOTS, 16, unit slots scanned per tick (slot index 0..15)
ATK_W, 8, width of one unit's attack value
SUM_W, 9, width of the total damage output
TOWER_SEL, 16, select code meaning "tower is the target"
NO_TARGET, 31, select code meaning "no target, decoder applies nothing"

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse that begins a scan; ignored while Busy
unitAlive  input  16  bit i set = slot i alive; latched at Start
unitInRange  input  16  bit i set = slot i engaged with target; latched at Start
targetIndex  input  5  0-15 unit, 16 tower, 17-31 none; latched at Start
attackAddr  output  4  slot index presented to attack table
attackData  input  8  attack of slot attackAddr, combinational, same cycle
totalDamage  output  9  saturated damage sum, held until next result
damageSelect  output  5  target code for the decoder, held with totalDamage
Busy  output  1  high while scanning
Done  output  1  one-cycle pulse: new totalDamage/damageSelect valid

Behaviour:
- Reset (Reset_n low, any time, async): totalDamage=0, damageSelect=31, Busy=0, Done=0, attackAddr=0, internal sum=0, state=IDLE.
- States: IDLE -> SCAN (Start sampled high in IDLE) -> IDLE. No other states.
- Edge 0 = edge sampling Start in IDLE: latch mask = unitAlive & unitInRange, latch targetIndex, clear sum, slot counter=0, Busy=1.
- SCAN: attackAddr = slot counter. At edges 1..16, if mask[slot] then sum += attackData, else sum unchanged. Counter then increments.
- Saturation: any add whose true result exceeds 511 gives 511. Once 511, sum stays 511 for that scan. No wrap.
- At edge 16, register the outputs using the final sum, including slot 15's contribution. totalDamage = final sum; damageSelect = latched target. Busy goes 0 and state returns to IDLE. Done is high for exactly the cycle between edges 16 and 17.
- Latched target 17-31: damageSelect=31 and totalDamage=0 regardless of the sum. The scan still takes 16 cycles and Done still pulses.
- Mask all zero: totalDamage=0, damageSelect=latched target (0-16).
- Start while Busy: ignored, no restart, latched values unchanged.
- Start in the Done cycle: state is already IDLE, so a new scan begins. Old outputs are held until the next edge 16.
- unitAlive, unitInRange and targetIndex changing mid-scan have no effect. attackData is sampled live each SCAN cycle.
- Reset_n low mid-scan: immediate return to reset values. No Done pulse. The next Start begins a fresh scan.
- Outputs are stable between Done pulses. The decoder may sample them at any time.

Test Plan:
- Hold Reset_n low, then release -> totalDamage=0, damageSelect=31, Busy=0, Done=0, attackAddr=0.
- All slots masked, table attack[i]=i+1, targetIndex=3, Start -> Done exactly 16 cycles after edge 0, totalDamage=136, damageSelect=3; Busy high for 16 cycles; attackAddr steps 0..15.
- All slots masked, every attack=255, targetIndex=16 -> totalDamage=511 (saturated, no wrap), damageSelect=16.
- unitAlive=16'hFFFF, unitInRange=16'h0005, attack[0]=10, attack[2]=20, others 100, targetIndex=7; toggle the masks and target mid-scan -> totalDamage=30, damageSelect=7.
- targetIndex=20 with nonzero mask -> totalDamage=0, damageSelect=31; Start pulsed again at scan cycle 5 -> ignored, Done still at cycle 16.
- Reset_n pulsed low during scan cycle 8 -> outputs at reset values, no Done; new Start with case-2 setup -> 136 after 16 cycles.
